// File: rtl/dmem_stage.sv
// Memory stage: issues LW/LBU/SW/SB over a valid/yumi handshake, holds upstream
// while the access is outstanding, and loads the writeback pipeline register.
package dmem_stage_pkg;

  typedef struct packed {
    logic is_mem_op_s;
    logic is_store_op_s;
    logic is_byte_op_s;
    logic op_writes_rf_s;
  } control_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] instr_me;
    control_s    control_me;
    logic [31:0] pc_me;
    logic [31:0] rs_val_me;
    logic [31:0] rd_val_me;
    logic [31:0] alu_result_me;
  } pipcut_me_s;

  typedef struct packed {
    logic [31:0] instr_wb;
    control_s    control_wb;
    logic [31:0] pc_wb;
    logic [31:0] rs_val_wb;
    logic [31:0] rd_val_wb;
    logic [31:0] alu_result_wb;
    mem_out_s    mem_i_wb;
  } pipcut_wb_s;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_REQ_SENT,
    DMEM_REQ_ACKED
  } dmem_req_state;

endpackage

module dmem_stage
  import dmem_stage_pkg::*;
#(
  parameter int data_mem_addr_width_gp = 12,
  parameter int stall_cnt_width_p      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  pipcut_me_s                        pipe_me_i,
  input  logic                              valid_me_i,
  input  mem_out_s                          mem_i,
  output mem_in_s                           mem_o,
  output logic [data_mem_addr_width_gp-1:0] mem_addr_o,
  output logic                              stall_o,
  output pipcut_wb_s                        pipe_wb_o,
  output logic                              valid_wb_o,
  output logic                              protocol_err_o,
  output logic [stall_cnt_width_p-1:0]      stall_cycles_o
);

  dmem_req_state                     state_q, state_d;
  pipcut_me_s                        req_q, req_d;
  pipcut_wb_s                        pipe_wb_q, pipe_wb_d;
  logic                              valid_wb_q, valid_wb_d;
  logic                              err_q, err_d;
  logic [stall_cnt_width_p-1:0]      stall_cnt_q, stall_cnt_d;

  logic                              mem_op, stall, done, load_rsp, wb_load;
  pipcut_me_s                        src;
  mem_in_s                           mem_req;
  logic [data_mem_addr_width_gp-1:0] addr;

  function automatic mem_in_s req_of(input pipcut_me_s p);
    mem_in_s r;
    r               = '0;
    r.valid         = 1'b1;
    r.wen           = p.control_me.is_store_op_s;
    r.byte_not_word = p.control_me.is_byte_op_s;
    r.write_data    = p.rd_val_me;
    return r;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    mem_req  = '0;
    addr     = '0;
    stall    = 1'b0;
    done     = 1'b0;
    load_rsp = 1'b0;
    src      = pipe_me_i;
    mem_op   = valid_me_i & pipe_me_i.control_me.is_mem_op_s;

    unique case (state_q)
      DMEM_IDLE: begin
        if (mem_op) begin
          req_d   = pipe_me_i;
          mem_req = req_of(pipe_me_i);
          addr    = pipe_me_i.alu_result_me[data_mem_addr_width_gp-1:0];
          if (!mem_i.yumi) begin
            state_d = DMEM_REQ_SENT;
            stall   = 1'b1;
          end else if (pipe_me_i.control_me.is_store_op_s) begin
            done = 1'b1;
          end else begin
            state_d = DMEM_REQ_ACKED;
            stall   = 1'b1;
          end
        end
      end
      // Past issue the stage works only from req_q, so upstream glitches are harmless.
      DMEM_REQ_SENT: begin
        src     = req_q;
        mem_req = req_of(req_q);
        addr    = req_q.alu_result_me[data_mem_addr_width_gp-1:0];
        stall   = 1'b1;
        if (mem_i.yumi) begin
          if (req_q.control_me.is_store_op_s) begin
            state_d = DMEM_IDLE;
            stall   = 1'b0;
            done    = 1'b1;
          end else begin
            state_d = DMEM_REQ_ACKED;
          end
        end
      end
      DMEM_REQ_ACKED: begin
        src   = req_q;
        stall = 1'b1;
        if (mem_i.valid) begin
          mem_req.yumi = 1'b1;
          stall        = 1'b0;
          done         = 1'b1;
          load_rsp     = 1'b1;
          state_d      = DMEM_IDLE;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase

    wb_load    = done | ((state_q == DMEM_IDLE) & valid_me_i & ~pipe_me_i.control_me.is_mem_op_s);
    valid_wb_d = wb_load;
    pipe_wb_d  = pipe_wb_q;
    if (wb_load) begin
      pipe_wb_d.instr_wb      = src.instr_me;
      pipe_wb_d.control_wb    = src.control_me;
      pipe_wb_d.pc_wb         = src.pc_me;
      pipe_wb_d.rs_val_wb     = src.rs_val_me;
      pipe_wb_d.rd_val_wb     = src.rd_val_me;
      pipe_wb_d.alu_result_wb = src.alu_result_me;
      pipe_wb_d.mem_i_wb      = '0;
      if (load_rsp) begin
        pipe_wb_d.mem_i_wb.valid     = 1'b1;
        pipe_wb_d.mem_i_wb.read_data = src.control_me.is_byte_op_s
                                     ? {24'b0, mem_i.read_data[7:0]} : mem_i.read_data;
      end
    end

    // Response data is only legal while waiting for it; a command accept only
    // while a request is on the bus. Either violation is otherwise ignored.
    err_d = err_q | (mem_i.valid & (state_q != DMEM_REQ_ACKED))
                  | (mem_i.yumi & ~mem_req.valid);
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DMEM_IDLE;
      req_q       <= '0;
      pipe_wb_q   <= '0;
      valid_wb_q  <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pipe_wb_q   <= pipe_wb_d;
      valid_wb_q  <= valid_wb_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational request outputs are forced quiet while reset is held.
  assign mem_o          = reset ? '0 : mem_req;
  assign mem_addr_o     = reset ? '0 : addr;
  assign stall_o        = ~reset & stall;
  assign pipe_wb_o      = pipe_wb_q;
  assign valid_wb_o     = valid_wb_q;
  assign protocol_err_o = err_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: directed cases plus random transactions
// checked against a per-transaction latency/result model.
module tb_dmem_stage;
  import dmem_stage_pkg::*;

  localparam int AW  = 12;
  localparam int SCW = 5;
  localparam int SAT = (1 << SCW) - 1;

  typedef enum int { K_ALU, K_LW, K_LBU, K_SW, K_SB } kind_e;

  logic             clk = 1'b0;
  logic             reset;
  pipcut_me_s       pipe_me_i;
  logic             valid_me_i;
  mem_out_s         mem_i;
  mem_in_s          mem_o;
  logic [AW-1:0]    mem_addr_o;
  logic             stall_o;
  pipcut_wb_s       pipe_wb_o;
  logic             valid_wb_o;
  logic             protocol_err_o;
  logic [SCW-1:0]   stall_cycles_o;

  int   n_vec = 0;
  int   n_err = 0;
  int   stall_sum = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  dmem_stage #(.data_mem_addr_width_gp(AW), .stall_cnt_width_p(SCW)) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_me_i     (pipe_me_i),
    .valid_me_i    (valid_me_i),
    .mem_i         (mem_i),
    .mem_o         (mem_o),
    .mem_addr_o    (mem_addr_o),
    .stall_o       (stall_o),
    .pipe_wb_o     (pipe_wb_o),
    .valid_wb_o    (valid_wb_o),
    .protocol_err_o(protocol_err_o),
    .stall_cycles_o(stall_cycles_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    valid_me_i = 1'b0;
    mem_i      = '0;
    @(posedge clk); #1;
    check("rst_mem_o", mem_o, '0);
    check("rst_addr", mem_addr_o, '0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_valid_wb", valid_wb_o, 1'b0);
    check("rst_pipe_wb", pipe_wb_o, '0);
    check("rst_perr", protocol_err_o, 1'b0);
    check("rst_stall_cnt", stall_cycles_o, '0);
    @(negedge clk);
    reset     = 1'b0;
    stall_sum = 0;
    exp_err   = 1'b0;
  endtask

  // One instruction: yd cycles until yumi, then vd cycles until read data.
  task automatic run_txn(input kind_e kind, input int yd, input int vd,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] rdata);
    pipcut_me_s  p;
    bit          is_mem, is_st, is_b;
    int          total;
    logic [31:0] exp_rd;
    is_mem = (kind != K_ALU);
    is_st  = (kind == K_SW) || (kind == K_SB);
    is_b   = (kind == K_LBU) || (kind == K_SB);
    p = '0;
    p.instr_me                  = $urandom;
    p.control_me.is_mem_op_s    = is_mem;
    p.control_me.is_store_op_s  = is_st;
    p.control_me.is_byte_op_s   = is_b;
    p.control_me.op_writes_rf_s = !is_st;
    p.pc_me                     = $urandom;
    p.rs_val_me                 = $urandom;
    p.rd_val_me                 = rd;
    p.alu_result_me             = alu;
    total = !is_mem ? 0 : (is_st ? yd : yd + vd);

    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      pipe_me_i = p;
      if (c > 0) begin
        // Upstream data may wobble while stalled; the stage must not care.
        pipe_me_i.rd_val_me     = $urandom;
        pipe_me_i.alu_result_me = $urandom;
      end
      valid_me_i      = 1'b1;
      mem_i.yumi      = is_mem && (c == yd);
      mem_i.valid     = is_mem && !is_st && (c == yd + vd);
      mem_i.read_data = mem_i.valid ? rdata : $urandom;
      #1;
      check("stall", stall_o, c < total);
      if (is_mem && c <= yd) begin
        check("req_valid", mem_o.valid, 1'b1);
        check("req_wen", mem_o.wen, is_st);
        check("req_byte", mem_o.byte_not_word, is_b);
        check("req_wdata", mem_o.write_data, rd);
        check("req_addr", mem_addr_o, alu[AW-1:0]);
      end else begin
        check("req_quiet", mem_o.valid, 1'b0);
      end
      check("rsp_yumi", mem_o.yumi, is_mem && !is_st && (c == total));
      @(posedge clk); #1;
      if (c < total) check("bubble", valid_wb_o, 1'b0);
    end

    stall_sum += total;
    exp_rd = (kind == K_LW) ? rdata : (kind == K_LBU) ? {24'b0, rdata[7:0]} : 32'h0;
    check("wb_valid", valid_wb_o, 1'b1);
    check("wb_instr", pipe_wb_o.instr_wb, p.instr_me);
    check("wb_ctrl", pipe_wb_o.control_wb, p.control_me);
    check("wb_pc", pipe_wb_o.pc_wb, p.pc_me);
    check("wb_alu", pipe_wb_o.alu_result_wb, alu);
    check("wb_rd", pipe_wb_o.rd_val_wb, rd);
    check("wb_rdata", pipe_wb_o.mem_i_wb.read_data, exp_rd);
    check("wb_mvalid", pipe_wb_o.mem_i_wb.valid, (kind == K_LW) || (kind == K_LBU));
    check("stall_cnt", stall_cycles_o, (stall_sum > SAT) ? SAT : stall_sum);
    check("perr", protocol_err_o, exp_err);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_me_i = 1'b0;
    mem_i      = '0;
    @(posedge clk); #1;
    check("idle_valid_wb", valid_wb_o, 1'b0);
  endtask

  task automatic spurious(input logic v, input logic y);
    @(negedge clk);
    valid_me_i  = 1'b0;
    mem_i.valid = v;
    mem_i.yumi  = y;
    #1;
    check("spur_stall", stall_o, 1'b0);
    check("spur_req", mem_o.valid, 1'b0);
    @(posedge clk); #1;
    exp_err = 1'b1;
    check("spur_perr", protocol_err_o, 1'b1);
    check("spur_valid_wb", valid_wb_o, 1'b0);
    idle_cycle();
    check("perr_sticky", protocol_err_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    valid_me_i = 1'b0;
    pipe_me_i  = '0;
    mem_i      = '0;
    do_reset();

    run_txn(K_ALU, 0, 0, 32'h1234, 32'h0, 32'h0);
    run_txn(K_SW, 0, 0, 32'h010, 32'hDEADBEEF, 32'h0);
    run_txn(K_LW, 2, 3, 32'h020, 32'h0, 32'hCAFEF00D);
    check("lw_stall_cycles", stall_cycles_o, 5);
    run_txn(K_LBU, 0, 1, 32'h031, 32'h0, 32'hAABBCC9F);
    idle_cycle();
    spurious(1'b1, 1'b0);
    run_txn(K_ALU, 0, 0, 32'h55, 32'h66, 32'h0);

    // Reset arriving while a load waits in DMEM_REQ_ACKED.
    @(negedge clk);
    pipe_me_i = '0;
    pipe_me_i.control_me.is_mem_op_s    = 1'b1;
    pipe_me_i.control_me.op_writes_rf_s = 1'b1;
    pipe_me_i.alu_result_me             = 32'h044;
    valid_me_i = 1'b1;
    mem_i      = '0;
    mem_i.yumi = 1'b1;
    #1;
    check("acked_entry_stall", stall_o, 1'b1);
    do_reset();
    run_txn(K_SW, 0, 0, 32'h048, 32'h12345678, 32'h0);

    spurious(1'b0, 1'b1);
    do_reset();

    for (int i = 0; i < 60; i++) begin
      kind_e k;
      k = kind_e'($urandom_range(4, 0));
      run_txn(k, $urandom_range(3, 0), $urandom_range(3, 1),
              $urandom, $urandom, $urandom);
      if ($urandom_range(3, 0) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
